alu_seq_ctrl: RTL and testbench

- Multi-cycle command sequencer in front of the shared 32-bit combinational ALU (ops: AND 000, OR 001, ADD 010, SUB 110).
- Accepts one calculator command at a time over a valid/ready interface.
- Single ALU ops complete in one pass; MUL (shift-add) and unsigned DIV/REM (restoring) are built by iterating ADD/SUB through the ALU.
- Returns result, zero flag and error flag over a valid/ready response channel.

---
 rtl/alu_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Command sequencer in front of a shared 32-bit combinational ALU.
// Single ops take one ALU pass; MUL (shift-add) and DIVU/REMU (restoring) iterate ADD/SUB.
`timescale 1ns/1ps
module alu_seq_ctrl #(
    parameter int DATA_W         = 32,
    parameter bit MUL_EARLY_EXIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_zero
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXEC = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    logic [2:0]        state;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] acc_q;   // MUL accumulator / DIV partial remainder
    logic [DATA_W-1:0] sh_q;    // operand A: multiplicand / quotient shifter
    logic [DATA_W-1:0] mp_q;    // operand B: multiplier / divisor
    logic [4:0]        cnt_q;

    logic [DATA_W:0]   rs;
    logic              div_ge;
    logic [DATA_W-1:0] div_rem;
    logic [DATA_W-1:0] div_q;
    logic [DATA_W-1:0] mul_acc;
    logic              mul_last;

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_DONE);

    // rem < divisor always holds, so 32 stored bits suffice; rs keeps the 33rd for the compare
    assign rs       = {acc_q, sh_q[DATA_W-1]};
    assign div_ge   = (rs >= {1'b0, mp_q});
    assign div_rem  = div_ge ? alu_r : rs[DATA_W-1:0];
    assign div_q    = {sh_q[DATA_W-2:0], div_ge};
    assign mul_acc  = mp_q[0] ? alu_r : acc_q;
    assign mul_last = (cnt_q == 5'd31) || (MUL_EARLY_EXIT && (mp_q[DATA_W-1:1] == '0));

    always_comb begin
        alu_x  = '0;
        alu_y  = '0;
        alu_op = ALU_AND;
        case (state)
            S_EXEC: begin
                if (!op_q[2]) begin
                    alu_x = sh_q;
                    alu_y = mp_q;
                    case (op_q[1:0])
                        2'd0:    alu_op = ALU_AND;
                        2'd1:    alu_op = ALU_OR;
                        2'd2:    alu_op = ALU_ADD;
                        default: alu_op = ALU_SUB;
                    endcase
                end
            end
            S_MUL: begin
                alu_x  = acc_q;
                alu_y  = sh_q;
                alu_op = ALU_ADD;
            end
            S_DIV: begin
                if (div_ge) begin
                    alu_x  = rs[DATA_W-1:0];
                    alu_y  = mp_q;
                    alu_op = ALU_SUB;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= '0;
            acc_q      <= '0;
            sh_q       <= '0;
            mp_q       <= '0;
            cnt_q      <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        sh_q  <= cmd_a;
                        mp_q  <= cmd_b;
                        acc_q <= '0;
                        cnt_q <= '0;
                        if (cmd_op == 3'd4) begin
                            state <= S_MUL;
                        end else if (cmd_op == 3'd5 || cmd_op == 3'd6) begin
                            if (cmd_b == '0) begin
                                rsp_result <= (cmd_op == 3'd5) ? '1 : cmd_a;
                                rsp_zero   <= (cmd_op == 3'd6) && (cmd_a == '0);
                                rsp_err    <= 1'b1;
                                state      <= S_DONE;
                            end else begin
                                state <= S_DIV;
                            end
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (op_q[2]) begin
                        rsp_result <= '0;
                        rsp_zero   <= 1'b1;
                        rsp_err    <= 1'b1;
                    end else begin
                        rsp_result <= alu_r;
                        rsp_zero   <= alu_zero;
                        rsp_err    <= 1'b0;
                    end
                    state <= S_DONE;
                end
                S_MUL: begin
                    acc_q <= mul_acc;
                    sh_q  <= {sh_q[DATA_W-2:0], 1'b0};
                    mp_q  <= {1'b0, mp_q[DATA_W-1:1]};
                    cnt_q <= cnt_q + 5'd1;
                    if (mul_last) begin
                        rsp_result <= mul_acc;
                        rsp_zero   <= (mul_acc == '0);
                        rsp_err    <= 1'b0;
                        state      <= S_DONE;
                    end
                end
                S_DIV: begin
                    acc_q <= div_rem;
                    sh_q  <= div_q;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        rsp_result <= (op_q == 3'd6) ? div_rem : div_q;
                        rsp_zero   <= ((op_q == 3'd6) ? div_rem : div_q) == '0;
                        rsp_err    <= 1'b0;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: arithmetic reference model with per-cycle compare,
// directed pins from the test plan, random commands with random response backpressure.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;
    logic [31:0] alu_x, alu_y, alu_r;
    logic [2:0]  alu_op;
    logic        alu_zero;

    logic        ee_cmd_valid = 1'b0;
    logic        ee_cmd_ready;
    logic [31:0] ee_a = '0;
    logic [31:0] ee_b = '0;
    logic        ee_rsp_valid;
    logic [31:0] ee_rsp_result;
    logic        ee_rsp_zero;
    logic        ee_rsp_err;
    logic [31:0] ee_alu_x, ee_alu_y, ee_alu_r;
    logic [2:0]  ee_alu_op;
    logic        ee_alu_zero;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
        case (op)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x + y;
            3'b110:  return x - y;
            default: return 32'h0;
        endcase
    endfunction

    assign alu_r       = alu_f(alu_x, alu_y, alu_op);
    assign alu_zero    = (alu_r == 32'h0);
    assign ee_alu_r    = alu_f(ee_alu_x, ee_alu_y, ee_alu_op);
    assign ee_alu_zero = (ee_alu_r == 32'h0);

    alu_seq_ctrl #(.DATA_W(32), .MUL_EARLY_EXIT(1'b0)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_r(alu_r), .alu_zero(alu_zero)
    );

    alu_seq_ctrl #(.DATA_W(32), .MUL_EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .reset(reset),
        .cmd_valid(ee_cmd_valid), .cmd_ready(ee_cmd_ready), .cmd_op(3'd4), .cmd_a(ee_a), .cmd_b(ee_b),
        .rsp_valid(ee_rsp_valid), .rsp_ready(1'b1), .rsp_result(ee_rsp_result),
        .rsp_zero(ee_rsp_zero), .rsp_err(ee_rsp_err),
        .alu_x(ee_alu_x), .alu_y(ee_alu_y), .alu_op(ee_alu_op), .alu_r(ee_alu_r), .alu_zero(ee_alu_zero)
    );

    // ---------------- reference model (arithmetic, not structural) ----------------
    function automatic logic [31:0] m_res_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: begin p = a * b; return p; end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_err_f(input logic [2:0] op, input logic [31:0] b);
        return (op == 3'd7) || ((op == 3'd5 || op == 3'd6) && b == 0);
    endfunction

    // edges from the accept edge (inclusive) to rsp_valid high
    function automatic int m_lat_f(input logic [2:0] op, input logic [31:0] b, input bit ee);
        int it;
        case (op)
            3'd4: begin
                if (!ee) return 33;
                it = 1;
                for (int i = 0; i < 32; i++) if (b[i]) it = i + 1;
                return 1 + it;
            end
            3'd5, 3'd6: return (b == 0) ? 1 : 33;
            default: return 2;
        endcase
    endfunction

    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;
    int          m_cnt = 0;
    int          m_lat = 0;
    logic [31:0] m_res = '0;
    logic        m_err = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (m_busy) begin
            if (m_valid) begin
                if (rsp_ready) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b0;
                end
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == m_lat) m_valid <= 1'b1;
            end
        end else if (cmd_valid) begin
            m_busy  <= 1'b1;
            m_cnt   <= 1;
            m_lat   <= m_lat_f(cmd_op, cmd_b, 1'b0);
            m_valid <= (m_lat_f(cmd_op, cmd_b, 1'b0) == 1);
            m_res   <= m_res_f(cmd_op, cmd_a, cmd_b);
            m_err   <= m_err_f(cmd_op, cmd_b);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout waiting for DUT at %0t", name, $time);
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (started && !reset) begin
            chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, !m_busy});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
            if (m_valid) begin
                chk("rsp_result", rsp_result, m_res);
                chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, m_res == 32'h0});
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
            end
            if (!m_busy || m_valid) begin
                chk("alu_idle_x", alu_x, 32'h0);
                chk("alu_idle_y", alu_y, 32'h0);
                chk("alu_idle_op", {29'b0, alu_op}, 32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] got_res;
    logic        got_err, got_zero;
    int          got_lat;
    bit          got_ok;

    task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit bp);
        int  n;
        int  lat;
        bit  seen;
        got_ok = 1'b0;
        got_lat = 0;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            timeout("cmd_accept");
            return;
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        @(posedge clk);
        lat = 1;
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cmd_valid = 1'b0;
                cmd_a = $urandom;
                cmd_b = $urandom;
                cmd_op = 3'($urandom);
            end
            if (rsp_valid && !seen) begin
                seen = 1'b1;
                got_lat = lat;
                got_res = rsp_result;
                got_err = rsp_err;
                got_zero = rsp_zero;
            end
            rsp_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk);
            if (seen && rsp_ready) begin
                got_ok = 1'b1;
                break;
            end
            lat++;
        end
        rsp_ready = 1'b1;
        if (!got_ok) timeout("rsp_handshake");
    endtask

    task automatic directed(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic exp_err, input int exp_lat);
        run_cmd(op, a, b, 1'b0);
        if (got_ok) begin
            chk({name, "_res"}, got_res, exp_res);
            chk({name, "_err"}, {31'b0, got_err}, {31'b0, exp_err});
            chk({name, "_zero"}, {31'b0, got_zero}, {31'b0, exp_res == 32'h0});
            chk({name, "_lat"}, got_lat, exp_lat);
        end
    endtask

    task automatic ee_run(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int  lat;
        bit  done;
        @(negedge clk);
        chk({name, "_ready"}, {31'b0, ee_cmd_ready}, 32'h1);
        ee_cmd_valid = 1'b1;
        ee_a = a;
        ee_b = b;
        @(posedge clk);
        lat = 1;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ee_cmd_valid = 1'b0;
            if (ee_rsp_valid) begin
                chk({name, "_res"}, ee_rsp_result, exp_res);
                chk({name, "_zero"}, {31'b0, ee_rsp_zero}, {31'b0, exp_res == 32'h0});
                chk({name, "_err"}, {31'b0, ee_rsp_err}, 32'h0);
                chk({name, "_lat"}, lat, exp_lat);
                done = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!done) timeout(name);
        @(posedge clk);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(1, 20));
            3:       return 32'h8000_0000 | 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] held;
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        int          n;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_rsp_zero", {31'b0, rsp_zero}, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        chk("rst_alu_x", alu_x, 32'h0);
        chk("rst_alu_y", alu_y, 32'h0);
        chk("rst_alu_op", {29'b0, alu_op}, 32'h0);
        reset = 1'b0;
        started = 1'b1;

        directed("add_wrap", 3'd2, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 2);
        directed("sub", 3'd3, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 2);
        directed("and", 3'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 2);
        directed("or", 3'd1, 32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 1'b0, 2);
        directed("mul", 3'd4, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b0, 33);
        directed("divu", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        directed("remu", 3'd6, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        directed("divu_big", 3'd5, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1, 1'b0, 33);
        directed("divu_z", 3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        directed("remu_z", 3'd6, 32'd9, 32'd0, 32'd9, 1'b1, 1);
        directed("illegal", 3'd7, 32'h1234_5678, 32'h9, 32'h0, 1'b1, 2);

        // backpressure: response held for 10 cycles while a competing command is offered
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 3'd2;
        cmd_a = 32'd40;
        cmd_b = 32'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) timeout("bp_valid");
        held = rsp_result;
        chk("bp_first", held, 32'd42);
        cmd_valid = 1'b1;
        cmd_op = 3'd0;
        cmd_a = 32'hFFFF_FFFF;
        cmd_b = 32'h1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", rsp_result, held);
            chk("bp_ready", {31'b0, cmd_ready}, 32'h0);
            chk("bp_valid", {31'b0, rsp_valid}, 32'h1);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle", {31'b0, cmd_ready}, 32'h1);
        chk("bp_drop", {31'b0, rsp_valid}, 32'h0);

        for (int t = 0; t < 150; t++) begin
            rop = 3'($urandom_range(0, 7));
            ra = pick_val();
            rb = pick_val();
            run_cmd(rop, ra, rb, 1'b1);
        end

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'd4;
        cmd_a = 32'h1234_5678;
        cmd_b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        chk("arst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("arst_rsp_result", rsp_result, 32'h0);
        chk("arst_rsp_zero", {31'b0, rsp_zero}, 32'h0);
        chk("arst_rsp_err", {31'b0, rsp_err}, 32'h0);
        chk("arst_alu_x", alu_x, 32'h0);
        chk("arst_alu_y", alu_y, 32'h0);
        chk("arst_alu_op", {29'b0, alu_op}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        directed("post_rst_add", 3'd2, 32'd2, 32'd3, 32'd5, 1'b0, 2);

        // early-exit multiplier instance
        ee_run("ee_3x5", 32'd3, 32'd5, 32'd15, 4);
        ee_run("ee_bzero", 32'hDEAD_BEEF, 32'd0, 32'd0, 2);
        ee_run("ee_topbit", 32'd3, 32'h8000_0000, 32'h8000_0000, 33);
        for (int t = 0; t < 10; t++) begin
            ra = $urandom;
            rb = 32'($urandom_range(0, 4095));
            ee_run("ee_rand", ra, rb, m_res_f(3'd4, ra, rb), m_lat_f(3'd4, rb, 1'b1));
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
